// File: rtl/lcd_timing_gen.sv
// RGB565 LCD timing generator: scan counters, stage-0 pixel coordinates, sprite window
// with frame-synchronous shadow origin, border overlay and frame/line interrupts.
module lcd_timing_gen #(
  parameter int          H_ACTIVE     = 800,
  parameter int          H_BP         = 46,
  parameter int          H_FP         = 294,
  parameter int          H_SYNC       = 2,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_BP         = 23,
  parameter int          V_FP         = 23,
  parameter int          V_SYNC       = 6,
  parameter bit          SYNC_ACT_LOW = 1'b1,
  parameter int          PIPE_LAT     = 2,
  parameter int          WIN_W        = 64,
  parameter int          WIN_H        = 64,
  parameter bit          BORDER_EN    = 1'b1,
  parameter logic [15:0] BORDER_COLOR = 16'hFFFF,
  localparam int         WIN_XB       = $clog2(WIN_W),
  localparam int         WIN_YB       = $clog2(WIN_H),
  localparam int         AW           = WIN_XB + WIN_YB
) (
  input  logic          clk_pix,
  input  logic          reset,
  output logic          LCD_CLK,
  output logic          LCD_HSYNC,
  output logic          LCD_VSYNC,
  output logic          LCD_DEN,
  output logic [4:0]    LCD_R,
  output logic [5:0]    LCD_G,
  output logic [4:0]    LCD_B,
  output logic          px_valid,
  output logic [15:0]   px_x,
  output logic [15:0]   px_y,
  output logic          win_hit,
  output logic [AW-1:0] win_addr,
  input  logic [15:0]   pix_in,
  input  logic [15:0]   win_pix_in,
  input  logic [15:0]   win_x_in,
  input  logic [15:0]   win_y_in,
  input  logic          win_set,
  input  logic [15:0]   line_cmp,
  output logic          frame_int,
  output logic          line_int
);

  localparam logic [15:0]        H_LAST   = 16'(H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [15:0]        V_LAST   = 16'(V_BP + V_ACTIVE + V_FP - 1);
  localparam logic               SYNC_OFF = SYNC_ACT_LOW;
  localparam logic signed [16:0] WIN_W_S  = 17'(WIN_W);
  localparam logic signed [16:0] WIN_H_S  = 17'(WIN_H);

  logic [15:0]        scan_x_q, scan_x_d, scan_y_q, scan_y_d;
  logic               frame_end, line_hit_d;
  logic               hs_raw, vs_raw, border;
  logic [PIPE_LAT:0]  hs_pipe_q, vs_pipe_q, den_pipe_q;
  logic [PIPE_LAT-1:0] brd_pipe_q, hit_pipe_q;
  logic [15:0]        rgb_q, rgb_d;
  logic [15:0]        wx_q, wy_q, pend_x_q, pend_y_q;
  logic               pend_q, frame_int_q, line_int_q;
  logic signed [16:0] x_s, y_s, wx_s, wy_s;
  logic               in_x, in_y;
  logic [WIN_XB-1:0]  dx;
  logic [WIN_YB-1:0]  dy;

  always_comb begin
    frame_end = (scan_x_q == H_LAST) && (scan_y_q == V_LAST);
    scan_x_d  = scan_x_q + 16'd1;
    scan_y_d  = scan_y_q;
    if (scan_x_q == H_LAST) begin
      scan_x_d = '0;
      scan_y_d = (scan_y_q == V_LAST) ? '0 : scan_y_q + 16'd1;
    end
    // Compare against the next scan position so line_int lands on scan_x==0 itself.
    line_hit_d = (scan_x_d == '0) && (line_cmp < 16'(V_ACTIVE)) &&
                 ({1'b0, scan_y_d} == (17'(V_BP) + {1'b0, line_cmp}));
  end

  always_comb begin
    px_valid = (scan_x_q >= 16'(H_BP)) && (scan_x_q < 16'(H_BP + H_ACTIVE)) &&
               (scan_y_q >= 16'(V_BP)) && (scan_y_q < 16'(V_BP + V_ACTIVE));
    px_x     = px_valid ? scan_x_q - 16'(H_BP) : '0;
    px_y     = px_valid ? scan_y_q - 16'(V_BP) : '0;
    hs_raw   = (scan_x_q < 16'(H_SYNC)) ^ SYNC_ACT_LOW;
    vs_raw   = (scan_y_q < 16'(V_SYNC)) ^ SYNC_ACT_LOW;
    border   = BORDER_EN && px_valid &&
               ((px_x == '0) || (px_x == 16'(H_ACTIVE - 1)) ||
                (px_y == '0) || (px_y == 16'(V_ACTIVE - 1)));
  end

  // Window compare in 17-bit signed space so negative origins and wx+WIN_W never wrap.
  always_comb begin
    x_s      = $signed({1'b0, px_x});
    y_s      = $signed({1'b0, px_y});
    wx_s     = $signed({wx_q[15], wx_q});
    wy_s     = $signed({wy_q[15], wy_q});
    in_x     = (x_s >= wx_s) && (x_s < wx_s + WIN_W_S);
    in_y     = (y_s >= wy_s) && (y_s < wy_s + WIN_H_S);
    dx       = WIN_XB'(x_s - wx_s);
    dy       = WIN_YB'(y_s - wy_s);
    win_hit  = px_valid && in_x && in_y;
    win_addr = win_hit ? {dy, dx} : '0;
  end

  always_comb begin
    rgb_d = '0;
    if (den_pipe_q[PIPE_LAT-1]) begin
      if (brd_pipe_q[PIPE_LAT-1])      rgb_d = BORDER_COLOR;
      else if (hit_pipe_q[PIPE_LAT-1]) rgb_d = win_pix_in;
      else                             rgb_d = pix_in;
    end
  end

  // win_set is a single-cycle strobe with no back-pressure: the origin is held as pending
  // and only becomes active at the last scan cycle of a frame.
  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      scan_x_q    <= '0;
      scan_y_q    <= '0;
      hs_pipe_q   <= {(PIPE_LAT + 1){SYNC_OFF}};
      vs_pipe_q   <= {(PIPE_LAT + 1){SYNC_OFF}};
      den_pipe_q  <= '0;
      brd_pipe_q  <= '0;
      hit_pipe_q  <= '0;
      rgb_q       <= '0;
      wx_q        <= '0;
      wy_q        <= '0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_q      <= 1'b0;
      frame_int_q <= 1'b0;
      line_int_q  <= 1'b0;
    end else begin
      scan_x_q      <= scan_x_d;
      scan_y_q      <= scan_y_d;
      hs_pipe_q[0]  <= hs_raw;
      vs_pipe_q[0]  <= vs_raw;
      den_pipe_q[0] <= px_valid;
      brd_pipe_q[0] <= border;
      hit_pipe_q[0] <= win_hit;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
        den_pipe_q[i] <= den_pipe_q[i-1];
      end
      for (int i = 1; i < PIPE_LAT; i++) begin
        brd_pipe_q[i] <= brd_pipe_q[i-1];
        hit_pipe_q[i] <= hit_pipe_q[i-1];
      end
      rgb_q <= rgb_d;
      if (frame_end && pend_q) begin
        wx_q <= pend_x_q;
        wy_q <= pend_y_q;
      end
      if (win_set) begin
        pend_x_q <= win_x_in;
        pend_y_q <= win_y_in;
        pend_q   <= 1'b1;
      end else if (frame_end) begin
        pend_q <= 1'b0;
      end
      frame_int_q <= frame_end;
      line_int_q  <= line_hit_d;
    end
  end

  assign LCD_CLK   = ~clk_pix;
  assign LCD_HSYNC = hs_pipe_q[PIPE_LAT];
  assign LCD_VSYNC = vs_pipe_q[PIPE_LAT];
  assign LCD_DEN   = den_pipe_q[PIPE_LAT];
  assign LCD_R     = rgb_q[15:11];
  assign LCD_G     = rgb_q[10:5];
  assign LCD_B     = rgb_q[4:0];
  assign frame_int = frame_int_q;
  assign line_int  = line_int_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a small 24x17 raster: cycle-count reference model with an
// expected-output queue, a window vector table, and directed reset/interrupt sequences.
module tb_lcd_timing_gen;

  localparam int HA = 16, HBP = 4, HFP = 4, HS = 2;
  localparam int VA = 12, VBP = 3, VFP = 2, VS = 1;
  localparam int LAT = 3, WW = 8, WH = 4, AW = 5;
  localparam int HT = HA + HBP + HFP;
  localparam int VT = VA + VBP + VFP;
  localparam int FT = HT * VT;
  localparam logic [15:0] BC = 16'hFFFF;

  logic          clk_pix = 1'b0;
  logic          reset;
  logic          LCD_CLK, LCD_HSYNC, LCD_VSYNC, LCD_DEN;
  logic [4:0]    LCD_R, LCD_B;
  logic [5:0]    LCD_G;
  logic          px_valid, win_hit, frame_int, line_int, win_set;
  logic [15:0]   px_x, px_y, pix_in, win_pix_in, win_x_in, win_y_in, line_cmp;
  logic [AW-1:0] win_addr;

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  int          mwx, mwy, mpx, mpy;
  bit          mpend;
  logic [15:0] prev_cmp;
  logic [18:0] exp_q[$];

  typedef struct {
    int wx; int wy; int px; int py; bit hit; int addr;
  } win_vec_t;
  win_vec_t vecs[7];

  always #5 clk_pix = ~clk_pix;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_BP(HBP), .H_FP(HFP), .H_SYNC(HS),
    .V_ACTIVE(VA), .V_BP(VBP), .V_FP(VFP), .V_SYNC(VS),
    .SYNC_ACT_LOW(1'b1), .PIPE_LAT(LAT), .WIN_W(WW), .WIN_H(WH),
    .BORDER_EN(1'b1), .BORDER_COLOR(BC)
  ) dut (
    .clk_pix(clk_pix), .reset(reset), .LCD_CLK(LCD_CLK),
    .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC), .LCD_DEN(LCD_DEN),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .win_hit(win_hit), .win_addr(win_addr),
    .pix_in(pix_in), .win_pix_in(win_pix_in),
    .win_x_in(win_x_in), .win_y_in(win_y_in), .win_set(win_set),
    .line_cmp(line_cmp), .frame_int(frame_int), .line_int(line_int)
  );

  function automatic logic [15:0] bg_pat(input int x, input int y);
    return {x[4:0], y[5:0], 5'd0};
  endfunction

  function automatic logic [15:0] win_pat(input int x, input int y);
    return {5'h1F, y[5:0], x[4:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, k, act, exp_v);
    end
  endtask

  task automatic check_reset(input string name);
    check(name,
          64'({LCD_HSYNC, LCD_VSYNC, LCD_DEN, LCD_R, LCD_G, LCD_B, frame_int, line_int,
               px_valid, px_x, px_y, win_hit, win_addr}),
          64'({1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 5'h0}));
  endtask

  task automatic model_reset();
    k = 0; mwx = 0; mwy = 0; mpx = 0; mpy = 0; mpend = 0;
    prev_cmp = line_cmp;
    exp_q.delete();
    repeat (LAT + 1) exp_q.push_back({1'b1, 1'b1, 1'b0, 16'h0});
  endtask

  // Called at the falling edge of cycle k: drive data, compare all outputs, advance one cycle.
  task automatic step();
    int sx, sy, ax, ay, t, tx, ty;
    bit act, hit, brd, hs, vs, fi, li;
    logic [AW-1:0] addr;
    logic [15:0]   rgb;
    logic [18:0]   e;
    t = k - LAT;
    pix_in = 16'hA5A5;
    win_pix_in = 16'h5A5A;
    if (t >= 0) begin
      tx = t % HT;
      ty = (t / HT) % VT;
      if (tx >= HBP && tx < HBP + HA && ty >= VBP && ty < VBP + VA) begin
        pix_in = bg_pat(tx - HBP, ty - VBP);
        win_pix_in = win_pat(tx - HBP, ty - VBP);
      end
    end
    sx  = k % HT;
    sy  = (k / HT) % VT;
    act = (sx >= HBP) && (sx < HBP + HA) && (sy >= VBP) && (sy < VBP + VA);
    ax  = act ? sx - HBP : 0;
    ay  = act ? sy - VBP : 0;
    hit = act && (ax >= mwx) && (ax < mwx + WW) && (ay >= mwy) && (ay < mwy + WH);
    addr = hit ? AW'((ay - mwy) * WW + (ax - mwx)) : '0;
    brd = act && (ax == 0 || ax == HA - 1 || ay == 0 || ay == VA - 1);
    rgb = !act ? 16'h0 : brd ? BC : hit ? win_pat(ax, ay) : bg_pat(ax, ay);
    hs  = !(sx < HS);
    vs  = !(sy < VS);
    check("stage0", 64'({px_valid, px_x, px_y, win_hit, win_addr}),
          64'({act, 16'(ax), 16'(ay), hit, addr}));
    exp_q.push_back({hs, vs, act, rgb});
    e = exp_q.pop_front();
    check("lcd_out", 64'({LCD_HSYNC, LCD_VSYNC, LCD_DEN, LCD_R, LCD_G, LCD_B}), 64'(e));
    fi = (k > 0) && (k % FT == 0);
    li = (k > 0) && (sx == 0) && (int'(prev_cmp) < VA) && (sy == VBP + int'(prev_cmp));
    check("irq", 64'({frame_int, line_int}), 64'({fi, li}));
    check("lcd_clk", 64'(LCD_CLK), 64'(1'b1));
    if (sx == HT - 1 && sy == VT - 1 && mpend) begin
      mwx = mpx; mwy = mpy; mpend = 0;
    end
    if (win_set) begin
      mpx = int'($signed(win_x_in));
      mpy = int'($signed(win_y_in));
      mpend = 1;
    end
    prev_cmp = line_cmp;
    k++;
    @(negedge clk_pix);
  endtask

  task automatic run_until(input int x, input int y);
    int n;
    n = 0;
    while (!((k % HT) == x && ((k / HT) % VT) == y)) begin
      if (n >= 2 * FT) begin
        checks++; errors++;
        $display("FAIL run_until (%0d,%0d) not reached within %0d cycles", x, y, n);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic pulse_win(input int x, input int y);
    win_x_in = 16'(x);
    win_y_in = 16'(y);
    win_set = 1'b1;
    step();
    win_set = 1'b0;
  endtask

  task automatic wait_frame_int(input string name);
    int n;
    n = 0;
    while (frame_int !== 1'b1 && n < 2 * FT) begin
      step();
      n++;
    end
    check(name, 64'(n), 64'(FT));
  endtask

  task automatic count_frame(input int exp_li);
    int den_n, hs_n, vs_n, li_n;
    den_n = 0; hs_n = 0; vs_n = 0; li_n = 0;
    repeat (FT) begin
      if (LCD_DEN) den_n++;
      if (!LCD_HSYNC) hs_n++;
      if (!LCD_VSYNC) vs_n++;
      if (line_int) li_n++;
      step();
    end
    check("den_per_frame", 64'(den_n), 64'(HA * VA));
    check("hsync_low_per_frame", 64'(hs_n), 64'(HS * VT));
    check("vsync_low_per_frame", 64'(vs_n), 64'(VS * HT));
    check("line_int_per_frame", 64'(li_n), 64'(exp_li));
  endtask

  initial begin
    vecs[0] = '{wx: -3,  wy: 2,  px: 4,  py: 5,  hit: 1'b1, addr: 31};
    vecs[1] = '{wx: -3,  wy: 2,  px: 5,  py: 5,  hit: 1'b0, addr: 0};
    vecs[2] = '{wx: 10,  wy: 9,  px: 15, py: 11, hit: 1'b1, addr: 21};
    vecs[3] = '{wx: 10,  wy: 9,  px: 10, py: 8,  hit: 1'b0, addr: 0};
    vecs[4] = '{wx: -20, wy: 0,  px: 0,  py: 0,  hit: 1'b0, addr: 0};
    vecs[5] = '{wx: 0,   wy: -2, px: 7,  py: 1,  hit: 1'b1, addr: 31};
    vecs[6] = '{wx: 0,   wy: -2, px: 0,  py: 2,  hit: 1'b0, addr: 0};

    reset = 1'b0; win_set = 1'b0; win_x_in = '0; win_y_in = '0;
    line_cmp = 16'd5; pix_in = '0; win_pix_in = '0;
    repeat (3) begin
      @(negedge clk_pix);
      check_reset("reset_state");
    end
    reset = 1'b1;
    model_reset();

    wait_frame_int("frame_int_latency_boot");
    count_frame(1);
    line_cmp = 16'd12;
    count_frame(0);
    line_cmp = 16'd11;
    count_frame(1);
    line_cmp = 16'd5;

    for (int i = 0; i < 7; i++) begin
      run_until(HBP, VBP + VA / 2);
      pulse_win(vecs[i].wx, vecs[i].wy);
      run_until(HT - 1, VT - 1);
      step();
      run_until(HBP + vecs[i].px, VBP + vecs[i].py);
      check($sformatf("win_vec%0d", i), 64'({win_hit, win_addr}),
            64'({vecs[i].hit, AW'(vecs[i].addr)}));
    end

    // A strobe on the frame's last cycle must wait a full frame before taking effect.
    run_until(HT - 1, VT - 1);
    pulse_win(2, 1);
    run_until(HBP + 1, VBP + 1);
    check("win_set_frame_end_deferred", 64'({win_hit, win_addr}), 64'({1'b1, 5'd25}));
    run_until(HT - 1, VT - 1);
    step();
    run_until(HBP + 3, VBP + 2);
    check("win_set_frame_end_applied", 64'({win_hit, win_addr}), 64'({1'b1, 5'd9}));

    run_until(HBP + 5, VBP + 4);
    #2;
    reset = 1'b0;
    #1;
    check_reset("reset_async_midframe");
    repeat (2) begin
      @(negedge clk_pix);
      check_reset("reset_hold_midframe");
    end
    reset = 1'b1;
    model_reset();
    wait_frame_int("frame_int_latency_after_reset");
    count_frame(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
